// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port, byte-writable block RAM between
// an instruction-fetch port (m0) and a data port (m1), with per-port lock for RMW.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [3:0]            m0_we,
  input  logic [31:0]           m0_wdata,
  input  logic                  m0_lock,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [3:0]            m1_we,
  input  logic [31:0]           m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  input  logic [31:0]           ram_douta
);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   m0_rvalid_q, m0_rvalid_d;
  logic   m1_rvalid_q, m1_rvalid_d;
  logic   gnt0, gnt1;

  // A locked port is the only grantable one; in ARB the port that did not win last goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      LOCK0: gnt0 = m0_req;
      LOCK1: gnt1 = m1_req;
      default: begin
        if (m0_req && m1_req) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    m0_rvalid_d = gnt0 && (m0_we == 4'b0000);
    m1_rvalid_d = gnt1 && (m1_we == 4'b0000);
    if (gnt0) begin
      last_d  = 1'b0;
      state_d = m0_lock ? LOCK0 : ARB;
    end else if (gnt1) begin
      last_d  = 1'b1;
      state_d = m1_lock ? LOCK1 : ARB;
    end else if (state_q == LOCK0 && !m0_lock) begin
      state_d = ARB;
    end else if (state_q == LOCK1 && !m1_lock) begin
      state_d = ARB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      last_q      <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  // Idle cycles park the address/data on m0 but the strobes stay low, so nothing is written.
  always_comb begin
    ram_addra = gnt1 ? m1_addr  : m0_addr;
    ram_dina  = gnt1 ? m1_wdata : m0_wdata;
    if (gnt0)
      ram_wea = m0_we;
    else if (gnt1)
      ram_wea = m1_we;
    else
      ram_wea = 4'b0000;
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = ram_douta;
  assign m1_rdata  = ram_douta;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed table-driven bench for bram_port_arbiter with a behavioural
// registered-read, byte-writable RAM model attached to the RAM port.
module tb_bram_port_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_lock, m1_req, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [3:0]    m0_we, m1_we;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_dina;
  logic [3:0]    ram_wea;
  logic [31:0]   ram_douta;

  logic [31:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea), .ram_douta(ram_douta)
  );

  // Read-first RAM model: 1-cycle registered read, byte strobes.
  always @(posedge clk) begin
    ram_douta <= mem[ram_addra];
    for (int b = 0; b < 4; b++)
      if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
  end

  typedef struct {
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic [3:0]    m0_we;
    logic [31:0]   m0_wdata;
    logic          m0_lock;
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic [3:0]    m1_we;
    logic [31:0]   m1_wdata;
    logic          m1_lock;
    logic          e_g0, e_g1, e_rv0, e_rv1;
    logic [31:0]   e_rdata;
    logic [3:0]    e_wea;
    logic [AW-1:0] e_addra;
    logic [31:0]   e_dina;
  } vec_t;

  function automatic vec_t v(
    input logic a0r, input logic [AW-1:0] a0a, input logic [3:0] a0w, input logic [31:0] a0d, input logic a0l,
    input logic a1r, input logic [AW-1:0] a1a, input logic [3:0] a1w, input logic [31:0] a1d, input logic a1l,
    input logic g0, input logic g1, input logic rv0, input logic rv1, input logic [31:0] rd,
    input logic [3:0] wea, input logic [AW-1:0] addra, input logic [31:0] dina);
    vec_t r;
    r.m0_req = a0r; r.m0_addr = a0a; r.m0_we = a0w; r.m0_wdata = a0d; r.m0_lock = a0l;
    r.m1_req = a1r; r.m1_addr = a1a; r.m1_we = a1w; r.m1_wdata = a1d; r.m1_lock = a1l;
    r.e_g0 = g0; r.e_g1 = g1; r.e_rv0 = rv0; r.e_rv1 = rv1; r.e_rdata = rd;
    r.e_wea = wea; r.e_addra = addra; r.e_dina = dina;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    m0_req = 0; m0_addr = '0; m0_we = 0; m0_wdata = 0; m0_lock = 0;
    m1_req = 0; m1_addr = '0; m1_we = 0; m1_wdata = 0; m1_lock = 0;
  endtask

  vec_t vecs [26];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[14'h020] = 32'h11223344;

    // seq A: lone m0 read
    vecs[0]  = v(1,'h010,0,0,0, 0,0,0,0,0,          1,0,0,0,0,            0,'h010,0);
    vecs[1]  = v(0,0,0,0,0, 0,0,0,0,0,              0,0,1,0,'hC0DE0010,   0,'h000,0);
    // seq B: m1 partial write then read-back
    vecs[2]  = v(0,0,0,0,0, 1,'h020,4'b0011,'hAABBCCDD,0, 0,1,0,0,0,      4'b0011,'h020,'hAABBCCDD);
    vecs[3]  = v(0,0,0,0,0, 1,'h020,0,0,0,          0,1,0,0,0,            0,'h020,0);
    vecs[4]  = v(0,0,0,0,0, 0,0,0,0,0,              0,0,0,1,'h1122CCDD,   0,'h000,0);
    // seq C: contention, round-robin
    vecs[5]  = v(1,'h100,0,0,0, 1,'h200,0,0,0,      1,0,0,0,0,            0,'h100,0);
    vecs[6]  = v(1,'h101,0,0,0, 1,'h200,0,0,0,      0,1,1,0,'hC0DE0100,   0,'h200,0);
    vecs[7]  = v(1,'h101,0,0,0, 1,'h201,0,0,0,      1,0,0,1,'hC0DE0200,   0,'h101,0);
    vecs[8]  = v(1,'h102,0,0,0, 1,'h201,0,0,0,      0,1,1,0,'hC0DE0101,   0,'h201,0);
    vecs[9]  = v(1,'h102,0,0,0, 1,'h202,0,0,0,      1,0,0,1,'hC0DE0201,   0,'h102,0);
    vecs[10] = v(1,'h103,0,0,0, 1,'h202,0,0,0,      0,1,1,0,'hC0DE0102,   0,'h202,0);
    vecs[11] = v(0,0,0,0,0, 0,0,0,0,0,              0,0,0,1,'hC0DE0202,   0,'h000,0);
    // seq D: m1 lock sequence with m0 waiting
    vecs[12] = v(1,'h300,0,0,0, 0,0,0,0,0,          1,0,0,0,0,            0,'h300,0);
    vecs[13] = v(1,'h301,0,0,0, 1,'h030,0,0,1,      0,1,1,0,'hC0DE0300,   0,'h030,0);
    vecs[14] = v(1,'h301,0,0,0, 1,'h030,4'hF,'h12345678,1, 0,1,0,1,'hC0DE0030, 4'hF,'h030,'h12345678);
    vecs[15] = v(1,'h301,0,0,0, 0,0,0,0,1,          0,0,0,0,0,            0,'h301,0);
    vecs[16] = v(1,'h301,0,0,0, 0,0,0,0,1,          0,0,0,0,0,            0,'h301,0);
    vecs[17] = v(1,'h301,0,0,0, 0,0,0,0,0,          0,0,0,0,0,            0,'h301,0);
    vecs[18] = v(1,'h301,0,0,0, 0,0,0,0,0,          1,0,0,0,0,            0,'h301,0);
    vecs[19] = v(0,0,0,0,0, 0,0,0,0,0,              0,0,1,0,'hC0DE0301,   0,'h000,0);
    vecs[20] = v(0,0,0,0,0, 1,'h030,0,0,0,          0,1,0,0,0,            0,'h030,0);
    vecs[21] = v(0,0,0,0,0, 0,0,0,0,0,              0,0,0,1,'h12345678,   0,'h000,0);
    // seq E: idle cycles
    vecs[22] = v(0,0,0,0,0, 0,0,0,0,0,              0,0,0,0,0,            0,'h000,0);
    vecs[23] = v(0,0,0,0,0, 0,0,0,0,0,              0,0,0,0,0,            0,'h000,0);
    vecs[24] = v(0,0,0,0,0, 0,0,0,0,0,              0,0,0,0,0,            0,'h000,0);
    // seq F: m0 alone, sets last=0 before the reset test
    vecs[25] = v(1,'h040,0,0,0, 0,0,0,0,0,          1,0,0,0,0,            0,'h040,0);

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rv0", 32'(m0_rvalid), 0);
    chk("reset_rv1", 32'(m1_rvalid), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #1;
      m0_req = vecs[i].m0_req; m0_addr = vecs[i].m0_addr; m0_we = vecs[i].m0_we;
      m0_wdata = vecs[i].m0_wdata; m0_lock = vecs[i].m0_lock;
      m1_req = vecs[i].m1_req; m1_addr = vecs[i].m1_addr; m1_we = vecs[i].m1_we;
      m1_wdata = vecs[i].m1_wdata; m1_lock = vecs[i].m1_lock;
      @(negedge clk);
      $display("vec %0d: g0=%b g1=%b rv0=%b rv1=%b rdata=%h wea=%b addra=%h",
               i, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, ram_wea, ram_addra);
      chk($sformatf("v%0d_m0_gnt", i), 32'(m0_gnt), 32'(vecs[i].e_g0));
      chk($sformatf("v%0d_m1_gnt", i), 32'(m1_gnt), 32'(vecs[i].e_g1));
      chk($sformatf("v%0d_m0_rvalid", i), 32'(m0_rvalid), 32'(vecs[i].e_rv0));
      chk($sformatf("v%0d_m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].e_rv1));
      chk($sformatf("v%0d_rv_overlap", i), 32'(m0_rvalid & m1_rvalid), 0);
      chk($sformatf("v%0d_ram_wea", i), 32'(ram_wea), 32'(vecs[i].e_wea));
      chk($sformatf("v%0d_ram_addra", i), 32'(ram_addra), 32'(vecs[i].e_addra));
      chk($sformatf("v%0d_ram_dina", i), ram_dina, vecs[i].e_dina);
      if (vecs[i].e_rv0) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].e_rdata);
      if (vecs[i].e_rv1) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].e_rdata);
    end

    // Reset in the cycle after the m0 read grant of vecs[25].
    @(posedge clk);
    #1;
    drive_idle();
    chk("pre_reset_rv0", 32'(m0_rvalid), 1);
    rst = 1'b1;
    #1;
    $display("reset asserted: rv0=%b rv1=%b", m0_rvalid, m1_rvalid);
    chk("reset_async_rv0", 32'(m0_rvalid), 0);
    @(negedge clk);
    chk("reset_hold_rv0_a", 32'(m0_rvalid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_hold_rv0_b", 32'(m0_rvalid), 0);
    chk("reset_hold_rv1", 32'(m1_rvalid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m0_req = 1; m0_addr = 14'h041;
    m1_req = 1; m1_addr = 14'h042;
    @(negedge clk);
    $display("post-reset contention: g0=%b g1=%b addra=%h", m0_gnt, m1_gnt, ram_addra);
    chk("post_reset_m0_gnt", 32'(m0_gnt), 1);
    chk("post_reset_m1_gnt", 32'(m1_gnt), 0);
    chk("post_reset_addra", 32'(ram_addra), 32'h041);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    $display("post-reset read: rv0=%b rv1=%b rdata=%h", m0_rvalid, m1_rvalid, m0_rdata);
    chk("post_reset_rv0", 32'(m0_rvalid), 1);
    chk("post_reset_rv1", 32'(m1_rvalid), 0);
    chk("post_reset_rdata", m0_rdata, 32'hC0DE0041);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Two-requester arbiter that shares one single-port, byte-writable block RAM between requester 0 (instruction fetch, read-only in practice) and requester 1 (data load/store).
- Sits between the Cortex-M0 fetch/data front-ends and the RAM macro.
- Issues at most one RAM access per cycle and routes the 1-cycle-latency read data back to the requester that owns it.
- Uses round-robin arbitration plus per-port lock for atomic read-modify-write sequences.

Parameters:
- ADDR_WIDTH, 14, word-address width, matching the RAM depth of 2**ADDR_WIDTH 32-bit words.

Ports:
- clk  input  1  system clock; RAM is clocked by the same clk.
- rst  input  1  asynchronous, active-high reset.
- m0_req  input  1  requester 0 access request; held until m0_gnt.
- m0_addr  input  ADDR_WIDTH  requester 0 word address.
- m0_we  input  4  requester 0 byte write strobes; 0 = read.
- m0_wdata  input  32  requester 0 write data.
- m0_lock  input  1  requester 0 keeps ownership after its grant.
- m0_gnt  output  1  request accepted this cycle (combinational).
- m0_rvalid  output  1  m0_rdata valid for requester 0's read.
- m0_rdata  output  32  read data.
- m1_req, m1_addr, m1_we, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as the m0 signals, for requester 1.
- ram_addra  output  ADDR_WIDTH  RAM address.
- ram_dina  output  32  RAM write data.
- ram_wea  output  4  RAM byte write enables.
- ram_douta  input  32  RAM registered read data, valid 1 cycle after the address.

Behaviour:
- State register `state` ∈ {ARB, LOCK0, LOCK1}; reset = ARB.
- Register `last` (index of the last granted port); reset = 1, so m0 wins the first contention.
- ARB state, grant (combinational):
  - Only one req high: grant that port.
  - Both req high: grant port != last.
  - Neither: no grant.
- LOCKx state:
  - Only port x is grantable.
  - The other port's gnt = 0 regardless of its req.
  - If port x has req = 0 in LOCKx, no access occurs and the state is held.
- State transitions, evaluated at the clock edge:
  - Grant to port x with mx_lock = 1 → LOCKx.
  - In LOCKx, cycle where mx_lock = 0 → ARB. That cycle is still arbitrated as LOCKx; m(1-x) can win from the next cycle.
  - No grant and state ARB → stay ARB.
- `last` updates to x on every grant to x, including grants in LOCKx.
- RAM drive when port x is granted: ram_addra = mx_addr, ram_dina = mx_wdata, ram_wea = mx_we.
- RAM drive when no grant: ram_wea = 4'b0000, ram_addra = m0_addr, ram_dina = m0_wdata. This must never produce a write.
- Writes (mx_we != 0): complete in the grant cycle; no rvalid is ever produced for a write.
- Partial strobes: written bytes are exactly those with the strobe set; the arbiter does not merge bytes.
- Reads (mx_we == 0):
  - mx_rvalid is a register set for exactly one cycle, the cycle after the grant.
  - Reset value of m0_rvalid and m1_rvalid = 0.
  - m0_rdata = m1_rdata = ram_douta, passed through combinationally; valid only while the matching rvalid is high.
- Back-to-back reads: throughput 1 access/cycle; rvalid pulses follow grants with a fixed 1-cycle offset.
- m0_rvalid and m1_rvalid are never high in the same cycle.
- Read-after-write to the same address by consecutive grants: the read returns the newly written data; the RAM provides this ordering and no forwarding is added.
- Simultaneous lock requests: arbitration picks a winner first; only the winner's lock takes effect.
- Reset mid-operation:
  - state → ARB, last → 1, both rvalid → 0 immediately.
  - Any in-flight read result is discarded.
  - A write already clocked into the RAM is not undone.
- Requesters must hold req/addr/we/wdata stable until gnt. Changing them before gnt is illegal; the arbiter does not check this.

Test Plan:
- After reset, m0 read addr 0x0010 alone: m0_gnt = 1 in cycle 0; m0_rvalid = 1 in cycle 1 with m0_rdata = preloaded mem[0x10]; m1_rvalid stays 0.
- m1 write addr 0x0020, we = 4'b0011, wdata = 0xAABBCCDD, over old 0x11223344; then m1 read 0x0020: ram_wea = 0011 during the write grant, no rvalid for the write; read returns 0x1122CCDD.
- Both requesters hold req with reads for 6 cycles:
  - Grants alternate 0,1,0,1,0,1, starting with m0 after reset.
  - Each rvalid follows its grant by 1 cycle on the correct port with the correct data.
  - rvalids are never overlapping.
- m1 read with m1_lock = 1, then m1 write with lock = 1, then m1 idle 2 cycles with lock = 1, then m1 lock = 0; m0_req held throughout:
  - m0_gnt = 0 for the whole locked period, including the idle cycles and the first lock = 0 cycle.
  - m0 is granted the following cycle.
- No requests for 3 cycles: ram_wea = 0 every cycle; no gnt; no rvalid.
- Assert rst in the cycle after an m0 read grant: m0_rvalid = 0 immediately and stays 0; after release, m0 wins the first contention with m1.
